dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter RAM_AW, default 16, SHALL be the data RAM word-index width.
REQ-002 Parameter DW, default 32, SHALL be the data width; 32 is the only legal value.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_valid  input  1  SHALL flag a core memory request.
REQ-006 req_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_size  input  2  SHALL give access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-009 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for sub-word loads.
REQ-010 req_addr  input  32  SHALL be the byte address.
REQ-011 req_wdata  input  32  SHALL be the store data, right-aligned.
REQ-012 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-013 resp_rdata  output  32  SHALL be the extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  SHALL flag an access fault, valid with resp_valid.
REQ-015 ram_wr_en  output  1  SHALL be the data RAM word write enable.
REQ-016 ram_addr  output  RAM_AW  SHALL be the data RAM word index.
REQ-017 ram_wdata  output  32  SHALL be the data RAM write word.
REQ-018 ram_rdata  input  32  SHALL be the data RAM combinational read word for ram_addr.

Function
REQ-019 FSM states: IDLE, ACCESS, WRITE, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready; on accept, we/size/unsigned/addr/wdata SHALL be registered.
REQ-021 Fault when: size==3; size 1 with addr[0]!=0; size 2 with addr[1:0]!=0; or any addr[31:RAM_AW+2] nonzero.
REQ-022 Faulting accept SHALL go IDLE->RESP with resp_err=1, no RAM write.
REQ-023 Legal accept SHALL go IDLE->ACCESS; ram_addr SHALL be the registered addr[RAM_AW+1:2] in ACCESS and WRITE, and 0 otherwise.
REQ-024 Load in ACCESS: select the byte/half lane by addr[1:0], extend per req_unsigned, register it to resp_rdata, go to RESP.
REQ-025 Word store in ACCESS: ram_wr_en=1, ram_wdata=wdata, go to RESP.
REQ-026 Sub-word store in ACCESS: merge wdata[7:0] or [15:0] into ram_rdata at the addressed lane, register the merged word, go to WRITE.
REQ-027 WRITE: ram_wr_en=1, ram_wdata=merged word, go to RESP.
REQ-028 ram_wr_en SHALL be decoded from the current state only and never asserted in IDLE or RESP.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata/resp_err SHALL hold until the next RESP.
REQ-030 Latency from the accept edge to the resp_valid cycle: fault 1; load and word store 2; sub-word store 3.
REQ-031 Back-to-back: a new request SHALL be accepted the cycle after RESP; a store's write SHALL be visible to the next load.

Reset
REQ-032 rst SHALL asynchronously force IDLE, resp_valid=0, resp_rdata=0, resp_err=0, ram_wr_en=0.
REQ-033 Reset during ACCESS or WRITE SHALL abort the operation: no write after rst rises and no response.

Structure
REQ-034 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state enum.
REQ-035 Sub-module dmem_lane (combinational) SHALL implement load extract/extend and store merge.

Verification
REQ-036 Word store 0xDEADBEEF @0x10, then lbu @0x13 -> 0x000000DE; lb @0x13 -> 0xFFFFFFDE.
REQ-037 sb 0x55 @0x11 over word 0xDEADBEEF -> two ram_wr_en-free cycles then one write of 0xDEAD55EF; resp 3 cycles after accept.
REQ-038 lh @0x12 over 0x8001xxxx -> resp_rdata 0xFFFF8001; lhu -> 0x00008001.
REQ-039 sw @0x6, lh @0x1, size 3, addr 0x0004_0000 (RAM_AW=16) -> resp_err=1 one cycle after accept, ram_wr_en never high.
REQ-040 rst pulse while in WRITE -> ram_wr_en low immediately, no resp_valid, RAM word unchanged; next request completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings for the data-memory load/store unit:
//            access-size codes and the LSU controller state enum.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Alignment check on the low address bits only; range checks live in the LSU.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      SZ_ILL:  misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_if
// Purpose  : Core-side request/response bus of the data-memory LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane
// Purpose  : Combinational byte/half lane logic: load extract + extend and
//            sub-word store merge into an existing RAM word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane
  import dmem_pkg::*;
(
  input  wire logic [1:0]  size,
  input  wire logic        is_unsigned,
  input  wire logic [1:0]  off,
  input  wire logic [31:0] word,
  input  wire logic [15:0] wdata,
  output logic      [31:0] load_data,
  output logic      [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_sh;

  // Pick the addressed lane and extend it for loads; splice new data for stores.
  always_comb begin
    w_sh = {off, 3'b000};
    case (off)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = off[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: load_data = is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: load_data = word;
    endcase

    case (size)
      SZ_BYTE: merged = (word & ~(32'h0000_00FF << w_sh)) | ({24'd0, wdata[7:0]} << w_sh);
      SZ_HALF: merged = (word & ~(32'h0000_FFFF << w_sh)) | ({16'd0, wdata} << w_sh);
      default: merged = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Data-memory load/store unit. Accepts one core request at a time,
//            checks alignment/range, performs loads, word stores and
//            read-modify-write sub-word stores against a combinational-read
//            word RAM, and returns a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int RAM_AW = 16,
  parameter int DW     = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  dmem_lsu_if.slave              bus,
  output logic                   ram_wr_en,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [DW-1:0]          ram_wdata,
  input  wire logic [DW-1:0]     ram_rdata
);

  state_t              r_state, w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [RAM_AW+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_merged;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_accept;
  logic                w_fault;
  logic                w_word_store;
  logic [31:0]         w_load;
  logic [31:0]         w_merge;

  assign w_accept     = bus.req_valid && bus.req_ready;
  // Any address bit above the RAM window makes the access out of range.
  assign w_fault      = misaligned(bus.req_size, bus.req_addr[1:0]) ||
                        ((bus.req_addr >> (RAM_AW + 2)) != 32'd0);
  assign w_word_store = r_we && (r_size == SZ_WORD);

  dmem_lane u_lane (
    .size        (r_size),
    .is_unsigned (r_uns),
    .off         (r_addr[1:0]),
    .word        (ram_rdata),
    .wdata       (r_wdata[15:0]),
    .load_data   (w_load),
    .merged      (w_merge)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next = (r_we && (r_size != SZ_WORD)) ? ST_WRITE : ST_RESP;
      ST_WRITE:  w_next = ST_RESP;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    bus.req_ready  = (r_state == ST_IDLE);
    bus.resp_valid = (r_state == ST_RESP);
    ram_wr_en      = 1'b0;
    ram_addr       = '0;
    ram_wdata      = r_wdata;
    case (r_state)
      ST_ACCESS: begin
        ram_addr  = r_addr[RAM_AW+1:2];
        ram_wr_en = w_word_store;
        ram_wdata = r_wdata;
      end
      ST_WRITE: begin
        ram_addr  = r_addr[RAM_AW+1:2];
        ram_wr_en = 1'b1;
        ram_wdata = r_merged;
      end
      default: ;
    endcase
  end

  // Request capture and response data; response fields change only on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_uns    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merged <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_we    <= bus.req_we;
          r_size  <= bus.req_size;
          r_uns   <= bus.req_unsigned;
          r_addr  <= bus.req_addr[RAM_AW+1:0];
          r_wdata <= bus.req_wdata;
          if (w_fault) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (r_we && (r_size != SZ_WORD)) begin
            r_merged <= w_merge;
          end else begin
            r_rdata <= r_we ? 32'd0 : w_load;
            r_err   <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Self-checking bench for dmem_lsu with a behavioural word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wword;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_wr_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [31:0] wr_last = '0;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        vecs [22];

  dmem_lsu_if bus ();

  dmem_lsu #(.RAM_AW(16), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ram_wr_en (ram_wr_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[7:0]];

  // Behavioural RAM write port plus write monitor.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_addr[7:0]] <= ram_wdata;
      wr_cnt             <= wr_cnt + 1;
      wr_last            <= ram_wdata;
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic err, input int lat,
                              input int nwr, input logic [31:0] ww);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_wr = nwr; v.exp_wword = ww;
    return v;
  endfunction

  task automatic drive_req(input vec_t v, input int idx);
    int to;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    to = 0;
    while (!bus.req_ready && to < 10) begin
      @(negedge clk);
      to++;
    end
    chk("req_ready", idx, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic run_req(input vec_t v, input int idx);
    int lat;
    int w0;
    logic [31:0] rd;
    logic er;
    drive_req(v, idx);
    w0 = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    chk("resp_valid", idx, {31'd0, bus.resp_valid}, 32'd1);
    chk("latency", idx, lat, v.exp_lat);
    chk("resp_rdata", idx, rd, v.exp_rdata);
    chk("resp_err", idx, {31'd0, er}, {31'd0, v.exp_err});
    @(posedge clk);
    #1;
    chk("resp_pulse", idx, {31'd0, bus.resp_valid}, 32'd0);
    chk("ready_after", idx, {31'd0, bus.req_ready}, 32'd1);
    chk("rdata_hold", idx, bus.resp_rdata, v.exp_rdata);
    chk("ram_writes", idx, wr_cnt - w0, v.exp_wr);
    if (v.exp_wr > 0) chk("ram_wword", idx, wr_last, v.exp_wword);
  endtask

  initial begin
    vec_t v;
    int   wc;
    int   seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;

    //          we  size uns addr          wdata         rdata         err lat wr  wword
    vecs[0]  = mk(1, 2'd2, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'd0, 1, 32'h13,       32'h0,        32'h000000DE, 0, 2, 0, 32'h0);
    vecs[2]  = mk(0, 2'd0, 0, 32'h13,       32'h0,        32'hFFFFFFDE, 0, 2, 0, 32'h0);
    vecs[3]  = mk(1, 2'd0, 0, 32'h11,       32'h55,       32'h0,        0, 3, 1, 32'hDEAD55EF);
    vecs[4]  = mk(0, 2'd2, 0, 32'h10,       32'h0,        32'hDEAD55EF, 0, 2, 0, 32'h0);
    vecs[5]  = mk(1, 2'd2, 0, 32'h20,       32'h80011234, 32'h0,        0, 2, 1, 32'h80011234);
    vecs[6]  = mk(0, 2'd1, 0, 32'h22,       32'h0,        32'hFFFF8001, 0, 2, 0, 32'h0);
    vecs[7]  = mk(0, 2'd1, 1, 32'h22,       32'h0,        32'h00008001, 0, 2, 0, 32'h0);
    vecs[8]  = mk(0, 2'd1, 0, 32'h20,       32'h0,        32'h00001234, 0, 2, 0, 32'h0);
    vecs[9]  = mk(0, 2'd0, 0, 32'h21,       32'h0,        32'h00000012, 0, 2, 0, 32'h0);
    vecs[10] = mk(1, 2'd1, 0, 32'h22,       32'hFFFFABCD, 32'h0,        0, 3, 1, 32'hABCD1234);
    vecs[11] = mk(0, 2'd2, 0, 32'h20,       32'h0,        32'hABCD1234, 0, 2, 0, 32'h0);
    vecs[12] = mk(1, 2'd2, 0, 32'h06,       32'h12345678, 32'h0,        1, 1, 0, 32'h0);
    vecs[13] = mk(0, 2'd2, 0, 32'h10,       32'h0,        32'hDEAD55EF, 0, 2, 0, 32'h0);
    vecs[14] = mk(0, 2'd1, 0, 32'h01,       32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[15] = mk(0, 2'd3, 0, 32'h10,       32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[16] = mk(0, 2'd2, 0, 32'h00040000, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[17] = mk(1, 2'd0, 0, 32'h22,       32'h000001FF, 32'h0,        0, 3, 1, 32'hABFF1234);
    vecs[18] = mk(0, 2'd0, 1, 32'h22,       32'h0,        32'h000000FF, 0, 2, 0, 32'h0);
    vecs[19] = mk(0, 2'd0, 0, 32'h22,       32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0);
    vecs[20] = mk(0, 2'd1, 1, 32'h10,       32'h0,        32'h000055EF, 0, 2, 0, 32'h0);
    vecs[21] = mk(0, 2'd0, 0, 32'h11,       32'h0,        32'h00000055, 0, 2, 0, 32'h0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 0, {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", 0, bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 0, {31'd0, bus.resp_err}, 32'd0);
    chk("rst_ram_wr_en", 0, {31'd0, ram_wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) run_req(vecs[i], i);

    // Reset while the sub-word store sits in WRITE: no write, no response.
    v = mk(1, 2'd0, 0, 32'h20, 32'h77, 32'h0, 0, 3, 1, 32'h0);
    drive_req(v, 100);
    wc = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("access_no_wr", 100, {31'd0, ram_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    chk("write_wr_en", 100, {31'd0, ram_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", 100, {31'd0, ram_wr_en}, 32'd0);
    chk("abort_resp_valid", 100, {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid || ram_wr_en) seen++;
    end
    chk("abort_quiet", 100, seen, 0);
    chk("abort_wr_cnt", 100, wr_cnt - wc, 0);
    chk("abort_mem", 100, mem[8], 32'hABFF1234);
    chk("abort_rdata", 100, bus.resp_rdata, 32'd0);
    run_req(mk(0, 2'd2, 0, 32'h20, 32'h0, 32'hABFF1234, 0, 2, 0, 32'h0), 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
